// File: rtl/serial_tx.sv
// serial_tx: asynchronous-style serial transmitter (start bit, DATA_W data
// bits LSB first, optional even-parity bit, one stop bit), each bit held for
// CLKS_PER_BIT clocks. The line and the handshake outputs are all driven
// straight from flops.
//
// Handshake: a word is accepted on a rising edge where tx_valid_i=1 and
// tx_ready_o=1. tx_ready_o is high only in IDLE and is registered, so it never
// depends combinationally on tx_valid_i. While tx_ready_o=0 the inputs are
// ignored entirely (no queueing, no overwrite of the frame in flight).
//
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// (XOR of the payload) between the last data bit and the stop bit.
module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              txd_o,
    output logic              busy_o,
    output logic [2:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_nx;
    logic              txd_q, txd_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              bit_last;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign tx_ready_o  = ready_q;
    assign txd_o       = txd_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

    // State register and registered outputs; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic; txd_d is the line value for the state being entered,
    // so the flop output lines up exactly with the state it belongs to.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        shift_nx = shift_q >> 1;
        bit_last = (cnt_q == CNT_LAST);
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                txd_d = 1'b1;
                if (tx_valid_i && ready_q) begin
                    shift_d  = tx_data_i;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^tx_data_i;
`endif
                    state_d  = START;
                    txd_d    = 1'b0;
                end
            end
            START: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        shift_d = shift_nx;
                        txd_d   = shift_nx[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (CLKS_PER_BIT=4 and =1). Each handshake
// pushes the expected per-cycle {busy, tx_ready, txd} of the whole frame plus
// the following IDLE cycle into exp_q; the bench pops and compares one entry
// per clock on the falling edge.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [1:0][7:0] tx_data;
  logic [1:0]      tx_valid;
  logic [1:0]      tx_ready;
  logic [1:0]      txd;
  logic [1:0]      busy;
  logic [2:0]      dbg_state0;
  logic [2:0]      dbg_state1;

  logic [2:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst(rst),
    .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
    .tx_ready_o(tx_ready[0]), .txd_o(txd[0]), .busy_o(busy[0]),
    .dbg_state_o(dbg_state0)
  );

  serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
    .tx_ready_o(tx_ready[1]), .txd_o(txd[1]), .busy_o(busy[1]),
    .dbg_state_o(dbg_state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] obs_of(input int sel);
    return {busy[sel], tx_ready[sel], txd[sel]};
  endfunction

  function automatic int cpb_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  // Expected {busy, ready, txd} per cycle after the handshake edge.
  task automatic push_frame(input logic [7:0] d, input int cpb);
    for (int c = 0; c < cpb; c++) exp_q.push_back(3'b100);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < cpb; c++) exp_q.push_back({2'b10, d[b]});
    if (PAR_EN)
      for (int c = 0; c < cpb; c++) exp_q.push_back({2'b10, ^d});
    for (int c = 0; c < cpb; c++) exp_q.push_back(3'b101);
    exp_q.push_back(3'b011);
  endtask

  // Called at a falling edge: offer a word, take the handshake edge, then
  // check the whole frame. With keep=1, tx_valid stays high and tx_data is
  // changed to nxt while the frame is busy.
  task automatic send(input string tag, input int sel, input logic [7:0] d,
                      input bit keep, input logic [7:0] nxt);
    logic [2:0] e;
    check($sformatf("%s_ready_pre", tag), 32'(tx_ready[sel]), 32'd1);
    tx_valid[sel] = 1'b1;
    tx_data[sel]  = d;
    @(posedge clk);
    push_frame(d, cpb_of(sel));
    for (int i = 1; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s_cyc%0d", tag, i), 32'(obs_of(sel)), 32'(e));
      if (i == 1) begin
        if (keep) tx_data[sel] = nxt;
        else      tx_valid[sel] = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int sel);
    check($sformatf("%s_txd", tag),   32'(txd[sel]),      32'd1);
    check($sformatf("%s_ready", tag), 32'(tx_ready[sel]), 32'd1);
    check($sformatf("%s_busy", tag),  32'(busy[sel]),     32'd0);
  endtask

  initial begin
    logic [2:0] e;
    logic [7:0] r;
    rst      = 1'b1;
    tx_valid = '0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    check_idle("rst4", 0);
    check_idle("rst1", 1);
    check("rst4_state", 32'(dbg_state0), 32'd0);
    check("rst1_state", 32'(dbg_state1), 32'd0);
    rst = 1'b0;

    // 8'hA5, 4 clocks per bit
    send("a5", 0, 8'hA5, 1'b0, 8'h00);

    // parity-sensitive payloads
    send("p07", 0, 8'h07, 1'b0, 8'h00);
    send("p03", 0, 8'h03, 1'b0, 8'h00);

    // tx_valid held high: 8'h01 then 8'h80, data changed while busy
    send("b2b_01", 0, 8'h01, 1'b1, 8'h80);
    send("b2b_80", 0, 8'h80, 1'b0, 8'h00);

    // reset during data bit 3 of 8'hFF aborts the frame
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'hFF;
    @(posedge clk);
    push_frame(8'hFF, 4);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("abort_cyc%0d", i), 32'(obs_of(0)), 32'(e));
      if (i == 1) tx_valid[0] = 1'b0;
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort_rst", 0);
    check("abort_state", 32'(dbg_state0), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("abort_after", 0);
    end
    send("post_abort_55", 0, 8'h55, 1'b0, 8'h00);

    // reset and handshake on the same edge: word not accepted
    rst         = 1'b1;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h3C;
    @(negedge clk);
    check_idle("rst_hs_0", 0);
    rst         = 1'b0;
    tx_valid[0] = 1'b0;
    @(negedge clk);
    check_idle("rst_hs_1", 0);
    @(negedge clk);
    check_idle("rst_hs_2", 0);

    // one clock per bit
    send("c3_cpb1", 1, 8'hC3, 1'b0, 8'h00);
    send("00_cpb1", 1, 8'h00, 1'b0, 8'h00);
    send("ff_cpb1", 1, 8'hFF, 1'b0, 8'h00);

    // random payloads on both instances
    repeat (3) begin
      r = 8'($urandom_range(0, 255));
      send($sformatf("rnd4_%02h", r), 0, r, 1'b0, 8'h00);
      r = 8'($urandom_range(0, 255));
      send($sformatf("rnd1_%02h", r), 1, r, 1'b0, 8'h00);
    end

    @(negedge clk);
    check_idle("end4", 0);
    check_idle("end1", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
